mfp_adc_max10_ahb: RTL and testbench
====================================

MFP_ADC_MAX10_AHB -- requirements
Module: mfp_adc_max10_ahb

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter ADDR_WIDTH, default 4: width of the word index driven to the ADC register core.
REQ-003 Parameter REG_COUNT, default 9: number of implemented registers, at word indices 0..REG_COUNT-1.
REQ-004 CLK  in  1  clock; all state updates on the rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 HSEL  in  1  slave select.
REQ-007 HADDR  in  32  address.
REQ-008 HWRITE  in  1  1 = write.
REQ-009 HTRANS  in  2  transfer type.
REQ-010 HSIZE  in  3  transfer size.
REQ-011 HBURST  in  3  burst type; ignored.
REQ-012 HWDATA  in  32  write data, valid in the data phase.
REQ-013 HREADY  in  1  bus ready; the previous transfer is complete.
REQ-014 HRDATA  out  32  read data.
REQ-015 HREADYOUT  out  1  slave ready.
REQ-016 HRESP  out  1  0 = OKAY, 1 = ERROR.
REQ-017 read_addr  out  ADDR_WIDTH  register index to the core.
REQ-018 read_data  in  32  combinational register contents from the core.
REQ-019 write_addr, write_data, write_enable  out  ADDR_WIDTH/32/1  register write port to the core.

Function
REQ-020 The block SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ).
- On acceptance, register HWRITE and index = HADDR[ADDR_WIDTH+1:2].
- IDLE or BUSY, or HSEL=0: no action; the response is OKAY with zero wait states.
REQ-021 The FSM SHALL have states S_IDLE, S_WRITE, S_READ, S_ERR1, S_ERR2.
- From S_IDLE, S_WRITE, S_READ or S_ERR2, an accepted transfer goes to S_WRITE or S_READ, or to S_ERR1 if the transfer is illegal (REQ-027).
- With no accepted transfer, these states go to S_IDLE.
- S_ERR1 always goes to S_ERR2.
REQ-022 In S_WRITE the block SHALL assert write_enable for exactly one cycle, with write_addr = captured index and write_data = HWDATA (combinational).
REQ-023 In S_READ the block SHALL drive read_addr = captured index and HRDATA = read_data, with zero wait states; HRDATA SHALL be 0 in all other states.
REQ-024 Outside S_READ, read_addr SHALL hold its last value.
REQ-025 HREADYOUT SHALL be 1 in every state except S_ERR1.
REQ-026 HRESP SHALL be 1 only in S_ERR1 and S_ERR2.
REQ-027 A transfer is illegal if any of the following holds:
- HSIZE is not 3'b010;
- HADDR[1:0] is not 0;
- the index is not below REG_COUNT.
REQ-028 An illegal transfer SHALL NOT assert write_enable.
REQ-029 A write in data phase N followed by a read of the same index in data phase N+1 SHALL return the newly written value; no forwarding logic is needed because the core updates at the end of cycle N.
REQ-030 An address phase presented during S_ERR1 SHALL be ignored, because HREADY=0 in that cycle.
REQ-031 An address phase presented during S_ERR2 SHALL be accepted normally.
REQ-032 Back-to-back accepted transfers SHALL complete at one per cycle.

Reset
REQ-033 While RESET=1, the block SHALL asynchronously force:
- State = S_IDLE;
- write_enable = 0;
- captured write flag and index = 0;
- read_addr = 0;
- HREADYOUT = 1, HRESP = 0, HRDATA = 0.
REQ-034 If RESET is asserted during S_WRITE or S_ERR1, the pending write or error SHALL be dropped; after reset the block SHALL start in S_IDLE.

Configuration
REQ-035 Macro MFP_ADC_AHB_ERROR_EN: when defined, the S_ERR1/S_ERR2 states and the illegal-transfer checks of REQ-027 SHALL be compiled in.
REQ-036 When MFP_ADC_AHB_ERROR_EN is undefined:
- every accepted transfer SHALL be treated as legal and complete OKAY with zero wait states;
- an out-of-range write SHALL be passed to the core unchanged, and the core ignores it;
- an out-of-range read SHALL return the core's default value, 0.

Verification
REQ-037 Write 32'h0000_0003 to HADDR 0x4, then read HADDR 0x4 -> write_enable pulses once with write_addr=1 and write_data=3; the read returns 3; HRESP=0 throughout.
REQ-038 Back-to-back write of 32'h55 to 0x4 followed by a read of 0x4 -> HRDATA=32'h55 in the read data phase; no wait states.
REQ-039 With the macro defined, write HSIZE=3'b000 to 0x4 -> HREADYOUT=0/HRESP=1 for one cycle, then HREADYOUT=1/HRESP=1 for one cycle; write_enable stays 0.
REQ-040 With the macro defined, read 0x24 (index 9) -> two-cycle ERROR response. With the macro undefined -> OKAY, HRDATA=0.
REQ-041 Assert RESET in the S_WRITE cycle -> write_enable=0 immediately; after reset, the first read of 0x4 returns the core's reset value.
REQ-042 HTRANS=BUSY with HSEL=1, and HSEL=0 with HTRANS=NONSEQ -> no write_enable; HREADYOUT=1; HRESP=0.

Source files
------------

// File: rtl/mfp_adc_max10_ahb.sv
// AHB-Lite slave bridging word-aligned transfers onto the MAX10 ADC register core.
// Define MFP_ADC_AHB_ERROR_EN to compile in the two-cycle ERROR response for illegal transfers.
module mfp_adc_max10_ahb #(
  parameter int ADDR_WIDTH = 4,
  parameter int REG_COUNT  = 9
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                state_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] read_addr_q;
  logic                  we_q;
  logic                  rd_q;
  logic                  hreadyout_q;
  logic                  hresp_q;

  logic                  xfer_accept;
  logic                  xfer_illegal;
  logic [ADDR_WIDTH-1:0] xfer_idx;

  assign xfer_accept = HSEL & HREADY & HTRANS[1];
  assign xfer_idx    = HADDR[ADDR_WIDTH+1:2];

`ifdef MFP_ADC_AHB_ERROR_EN
  assign xfer_illegal = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) ||
                        (int'(xfer_idx) >= REG_COUNT);
`else
  assign xfer_illegal = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      read_addr_q <= '0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      // ERR1 stalls the bus, so any address phase seen there is not real.
      if (state_q == S_ERR1) begin
        state_q <= S_ERR2;
        hresp_q <= 1'b1;
      end else if (xfer_accept) begin
        wr_q  <= HWRITE;
        idx_q <= xfer_idx;
        if (xfer_illegal) begin
          state_q     <= S_ERR1;
          hreadyout_q <= 1'b0;
          hresp_q     <= 1'b1;
        end else if (HWRITE) begin
          state_q <= S_WRITE;
          we_q    <= 1'b1;
        end else begin
          state_q     <= S_READ;
          rd_q        <= 1'b1;
          read_addr_q <= xfer_idx;
        end
      end else begin
        state_q <= S_IDLE;
      end
    end
  end

  assign write_enable = we_q;
  assign write_addr   = idx_q;
  assign write_data   = HWDATA;
  assign read_addr    = read_addr_q;
  assign HRDATA       = rd_q ? read_data : 32'h0;
  assign HREADYOUT    = hreadyout_q;
  assign HRESP        = hresp_q;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HSIZE, HADDR[31:ADDR_WIDTH+2], HADDR[1:0], wr_q};

endmodule

// File: tb/tb_mfp_adc_max10_ahb.sv
// Self-checking bench for mfp_adc_max10_ahb: directed cases plus random AHB traffic vs a transfer-level model.
module tb_mfp_adc_max10_ahb;

  localparam int REG_COUNT = 9;
`ifdef MFP_ADC_AHB_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  read_addr;
  logic [31:0] read_data;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;

  always #5 CLK = ~CLK;

  // Single-slave bus: the slave's ready is the bus ready.
  assign HREADY = HREADYOUT;

  mfp_adc_max10_ahb #(.ADDR_WIDTH(4), .REG_COUNT(REG_COUNT)) dut (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .read_addr(read_addr), .read_data(read_data), .write_addr(write_addr),
    .write_data(write_data), .write_enable(write_enable)
  );

  // Stand-in for the ADC register core: resettable registers, out-of-range reads as 0.
  logic [31:0] core_mem [REG_COUNT];
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < REG_COUNT; i++) core_mem[i] <= 32'h0;
    end else if (write_enable && int'(write_addr) < REG_COUNT) begin
      core_mem[write_addr] <= write_data;
    end
  end
  assign read_data = (int'(read_addr) < REG_COUNT) ? core_mem[read_addr] : 32'h0;

  int checks = 0;
  int errors = 0;

  // Transfer-level model: expected register contents and the transfer whose data phase is current.
  logic [31:0] mem [REG_COUNT];
  bit dp_valid, dp_write, dp_bad, err2;
  int dp_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_COUNT; i++) mem[i] = 32'h0;
    dp_valid = 0; dp_write = 0; dp_bad = 0; err2 = 0; dp_idx = 0;
  endtask

  task automatic step(input bit sel, input logic [1:0] trans, input bit wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    bit e_ready, e_resp, e_we, acc;
    logic [31:0] e_rdata;
    int idx;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    HWDATA = wdata; HBURST = 3'($urandom);
    @(negedge CLK);
    e_ready = 1; e_resp = 0; e_we = 0; e_rdata = 32'h0;
    if (err2) e_resp = 1;
    else if (dp_valid && dp_bad) begin e_ready = 0; e_resp = 1; end
    else if (dp_valid && dp_write) e_we = 1;
    else if (dp_valid) e_rdata = (dp_idx < REG_COUNT) ? mem[dp_idx] : 32'h0;
    chk("HREADYOUT", 32'(HREADYOUT), 32'(e_ready));
    chk("HRESP", 32'(HRESP), 32'(e_resp));
    chk("write_enable", 32'(write_enable), 32'(e_we));
    chk("HRDATA", HRDATA, e_rdata);
    if (e_we) begin
      chk("write_addr", 32'(write_addr), 32'(dp_idx));
      chk("write_data", write_data, wdata);
      if (dp_idx < REG_COUNT) mem[dp_idx] = wdata;
    end
    if (dp_valid && !dp_bad && !dp_write) chk("read_addr", 32'(read_addr), 32'(dp_idx));
    $display("step sel=%0d trans=%0d wr=%0d addr=%h size=%0d wdata=%h | rdy=%0d resp=%0d we=%0d rdata=%h",
             sel, trans, wr, addr, size, wdata, HREADYOUT, HRESP, write_enable, HRDATA);
    acc  = sel && trans[1] && e_ready;
    err2 = dp_valid && dp_bad;
    idx  = int'((addr >> 2) & 32'hF);
    dp_valid = acc;
    dp_write = wr;
    dp_idx   = idx;
    dp_bad   = ERR_EN && ((size != 3'b010) || (addr[1:0] != 2'b00) || (idx >= REG_COUNT));
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 32'h0, 3'b010, $urandom);
  endtask

  initial begin
    logic [31:0] a;
    RESET = 1; HSEL = 0; HTRANS = 0; HWRITE = 0; HADDR = 0; HSIZE = 3'b010;
    HBURST = 0; HWDATA = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_HREADYOUT", 32'(HREADYOUT), 32'd1);
    chk("rst_HRESP", 32'(HRESP), 32'd0);
    chk("rst_HRDATA", HRDATA, 32'd0);
    chk("rst_write_enable", 32'(write_enable), 32'd0);
    chk("rst_read_addr", 32'(read_addr), 32'd0);
    @(posedge CLK); #1;
    RESET = 0;

    // Write 3 to 0x4, then read it back.
    step(1, 2'b10, 1, 32'h4, 3'b010, $urandom);
    step(0, 2'b00, 0, 32'h0, 3'b010, 32'h3);
    step(1, 2'b10, 0, 32'h4, 3'b010, $urandom);
    idle();

    // Back-to-back write then read of the same index.
    step(1, 2'b10, 1, 32'h4, 3'b010, $urandom);
    step(1, 2'b11, 0, 32'h4, 3'b010, 32'h55);
    idle();

    // BUSY with select, and NONSEQ without select: no action.
    step(1, 2'b01, 1, 32'h8, 3'b010, $urandom);
    step(0, 2'b10, 1, 32'h8, 3'b010, $urandom);
    idle();

    // Byte-size write; then an address phase in the stall cycle and one in the next.
    step(1, 2'b10, 1, 32'h4, 3'b000, $urandom);
    step(1, 2'b10, 1, 32'h8, 3'b010, $urandom);
    step(1, 2'b10, 0, 32'h4, 3'b010, $urandom);
    idle();
    idle();

    // Out-of-range read, out-of-range write, unaligned read.
    step(1, 2'b10, 0, 32'h24, 3'b010, $urandom);
    idle();
    idle();
    step(1, 2'b10, 1, 32'h28, 3'b010, $urandom);
    idle();
    idle();
    step(1, 2'b10, 0, 32'h6, 3'b010, $urandom);
    idle();
    idle();

    // Reset while the write data phase is active drops the write.
    step(1, 2'b10, 1, 32'h4, 3'b010, $urandom);
    HSEL = 0; HTRANS = 0; HWDATA = 32'hDEAD_BEEF;
    RESET = 1;
    #1;
    chk("rstw_write_enable", 32'(write_enable), 32'd0);
    chk("rstw_HREADYOUT", 32'(HREADYOUT), 32'd1);
    chk("rstw_HRESP", 32'(HRESP), 32'd0);
    chk("rstw_read_addr", 32'(read_addr), 32'd0);
    @(posedge CLK); #1;
    RESET = 0;
    model_reset();
    step(1, 2'b10, 0, 32'h4, 3'b010, $urandom);
    idle();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, 12)) << 2;
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      step(($urandom_range(0, 4) != 0), 2'($urandom), 1'($urandom), a,
           ($urandom_range(0, 9) == 0) ? 3'b000 : 3'b010, $urandom);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
